// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
package wb_pkg;
    localparam int REG_COUNT = 32;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 3;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order result FIFO with two ordered push ports (0 before 1) and one pop.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push0,
    input  wb_entry_t     din0,
    input  logic          push1,
    input  wb_entry_t     din1,
    input  logic          pop,
    output wb_entry_t     head,
    output logic [CW-1:0] count
);
    wb_entry_t       mem [DEPTH];
    logic [AW-1:0]   rd, wr;

    // Caller never pushes beyond the free space, so pointers wrap without checks.
    always_ff @(posedge clk) begin
        if (push0) mem[wr] <= din0;
        if (push1) mem[wr + AW'(push0)] <= din1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            wr    <= wr + AW'(push0) + AW'(push1);
            rd    <= rd + AW'(pop);
            count <= count + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end

    assign head = mem[rd];
endmodule

// File: rtl/writeback_arbiter.sv
// Two-producer writeback arbiter with pending-write scoreboard.
// Optional WB_BYPASS_EN: p0 skips the empty FIFO straight into the output registers.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic [4:0]  p0_addr,
    input  logic [31:0] p0_data,
    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic [4:0]  p1_addr,
    input  logic [31:0] p1_data,
    input  logic        reserve_valid,
    input  logic [4:0]  reserve_addr,
    output logic        reserve_ready,
    input  logic [4:0]  query_addr0,
    input  logic [4:0]  query_addr1,
    output logic        busy0,
    output logic        busy1,
    output logic        regwe,
    output logic [4:0]  writeaddr,
    output logic [31:0] writedata
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]    count, free;
    wb_entry_t        head, e0, e1;
    logic             p0_take, p1_take, byp, pop;
    logic [CNT_W-1:0] cnt [REG_COUNT];
    logic             inc_hit;

    // Readiness looks only at registered occupancy; a same-cycle pop gives no credit.
    assign free     = CW'(DEPTH) - count;
    assign p0_ready = !reset && (free >= CW'(1));
    assign p1_ready = !reset && (p0_valid ? (free >= CW'(2)) : (free >= CW'(1)));

    assign p0_take = p0_valid && p0_ready && (p0_addr != 5'd0);
    assign p1_take = p1_valid && p1_ready && (p1_addr != 5'd0);
    assign e0      = '{addr: p0_addr, data: p0_data};
    assign e1      = '{addr: p1_addr, data: p1_data};
    assign pop     = (count != '0);

`ifdef WB_BYPASS_EN
    assign byp = p0_take && (count == '0);
`else
    assign byp = 1'b0;
`endif

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push0 (p0_take && !byp),
        .din0  (e0),
        .push1 (p1_take),
        .din1  (e1),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            regwe     <= 1'b0;
            writeaddr <= '0;
            writedata <= '0;
        end else if (byp) begin
            regwe     <= 1'b1;
            writeaddr <= p0_addr;
            writedata <= p0_data;
        end else if (pop) begin
            regwe     <= 1'b1;
            writeaddr <= head.addr;
            writedata <= head.data;
        end else begin
            regwe     <= 1'b0;
        end
    end

    assign reserve_ready = !reset && ((reserve_addr == 5'd0) || (cnt[reserve_addr] != '1));
    assign inc_hit       = reserve_valid && reserve_ready && (reserve_addr != 5'd0);

    // cnt[0] is never touched outside reset, so x0 always reads as idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) cnt[i] <= '0;
        end else begin
            for (int i = 1; i < REG_COUNT; i++) begin
                if (inc_hit && reserve_addr == 5'(i) && !(regwe && writeaddr == 5'(i)))
                    cnt[i] <= cnt[i] + CNT_W'(1);
                else if (regwe && writeaddr == 5'(i) && !(inc_hit && reserve_addr == 5'(i))
                         && cnt[i] != '0)
                    cnt[i] <= cnt[i] - CNT_W'(1);
            end
        end
    end

    assign busy0 = !reset && (query_addr0 != 5'd0) && (cnt[query_addr0] != '0);
    assign busy1 = !reset && (query_addr1 != 5'd0) && (cnt[query_addr1] != '0);
endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized bench for writeback_arbiter against a queue-based reference model.
module tb_writeback_arbiter;
    import wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int CMAX  = 7;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_valid, p0_ready, p1_valid, p1_ready;
    logic [4:0]  p0_addr, p1_addr;
    logic [31:0] p0_data, p1_data;
    logic        reserve_valid, reserve_ready;
    logic [4:0]  reserve_addr, query_addr0, query_addr1;
    logic        busy0, busy1, regwe;
    logic [4:0]  writeaddr;
    logic [31:0] writedata;

    writeback_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_data(p0_data),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_data(p1_data),
        .reserve_valid(reserve_valid), .reserve_addr(reserve_addr), .reserve_ready(reserve_ready),
        .query_addr0(query_addr0), .query_addr1(query_addr1), .busy0(busy0), .busy1(busy1),
        .regwe(regwe), .writeaddr(writeaddr), .writedata(writedata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: pending writes as a queue, output registers, per-register counts.
    wb_entry_t   q[$];
    bit          m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    int          mcnt [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_r0();
        return !reset && (DEPTH - q.size()) >= 1;
    endfunction
    function automatic bit m_r1();
        return !reset && (p0_valid ? (DEPTH - q.size()) >= 2 : (DEPTH - q.size()) >= 1);
    endfunction
    function automatic bit m_rr();
        return !reset && (reserve_addr == 0 || mcnt[reserve_addr] != CMAX);
    endfunction

    task automatic compare_all();
        chk("regwe", regwe, m_we);
        chk("writeaddr", writeaddr, m_wa);
        chk("writedata", writedata, m_wd);
        chk("p0_ready", p0_ready, m_r0());
        chk("p1_ready", p1_ready, m_r1());
        chk("reserve_ready", reserve_ready, m_rr());
        chk("busy0", busy0, !reset && query_addr0 != 0 && mcnt[query_addr0] != 0);
        chk("busy1", busy1, !reset && query_addr1 != 0 && mcnt[query_addr1] != 0);
    endtask

    task automatic model_update();
        bit acc0, acc1, rsv, old_we, bypass;
        logic [4:0] old_wa;
        wb_entry_t e;
        if (reset) begin
            q.delete();
            m_we = 0; m_wa = '0; m_wd = '0;
            for (int r = 0; r < 32; r++) mcnt[r] = 0;
            return;
        end
        acc0   = p0_valid && m_r0() && p0_addr != 0;
        acc1   = p1_valid && m_r1() && p1_addr != 0;
        rsv    = reserve_valid && m_rr() && reserve_addr != 0;
        old_we = m_we;
        old_wa = m_wa;
        bypass = BYP && acc0 && q.size() == 0;
        if (bypass) begin
            m_we = 1; m_wa = p0_addr; m_wd = p0_data;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            m_we = 1; m_wa = e.addr; m_wd = e.data;
        end else begin
            m_we = 0;
        end
        if (acc0 && !bypass) q.push_back('{addr: p0_addr, data: p0_data});
        if (acc1) q.push_back('{addr: p1_addr, data: p1_data});
        for (int r = 1; r < 32; r++) begin
            int d;
            d = ((rsv && reserve_addr == r) ? 1 : 0) - ((old_we && old_wa == r) ? 1 : 0);
            if (d > 0) mcnt[r]++;
            else if (d < 0 && mcnt[r] > 0) mcnt[r]--;
        end
    endtask

    // Inputs are set at the negedge before calling; check, clock, then return at next negedge.
    task automatic step();
        #1 compare_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        p0_valid = 0; p1_valid = 0; reserve_valid = 0;
    endtask

    initial begin
        reset = 1; idle();
        p0_addr = 0; p0_data = 0; p1_addr = 0; p1_data = 0;
        reserve_addr = 0; query_addr0 = 0; query_addr1 = 0;
        m_we = 0; m_wa = 0; m_wd = 0;
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
        @(negedge clk);
        p0_valid = 1;
        #1 chk("reset p0_ready", p0_ready, 0);
        p0_valid = 0;
        step();
        chk("reset regwe", regwe, 0);
        chk("reset writeaddr", writeaddr, 0);
        chk("reset writedata", writedata, 0);
        step();
        reset = 0;

        // single write
        p0_valid = 1; p0_addr = 5; p0_data = 32'hDEADBEEF;
        step(); idle();
        chk("single c1 regwe", regwe, BYP);
        step();
        chk("single c2 regwe", regwe, !BYP);
        chk("single c2 addr", writeaddr, 5);
        chk("single c2 data", writedata, 32'hDEADBEEF);
        step();
        chk("single c3 regwe", regwe, 0);

        // dual same-cycle, same register
        p0_valid = 1; p0_addr = 3; p0_data = 32'h11;
        p1_valid = 1; p1_addr = 3; p1_data = 32'h22;
        step(); idle();
        chk("dual c1 regwe", regwe, BYP);
        step();
        chk("dual c2 regwe", regwe, 1);
        chk("dual c2 data", writedata, BYP ? 32'h22 : 32'h11);
        step();
        chk("dual c3 regwe", regwe, !BYP);
        chk("dual c3 data", writedata, 32'h22);
        repeat (2) step();

        // fill to free==1 with both producers active
        p0_valid = 1; p0_addr = 9;  p0_data = 32'h99;
        p1_valid = 1; p1_addr = 10; p1_data = 32'hAA;
        repeat (3) step();
        #1;
        chk("free1 p0_ready", p0_ready, 1);
        chk("free1 p1_ready w/ p0", p1_ready, 0);
        p0_valid = 0;
        #1 chk("free1 p1_ready alone", p1_ready, 1);
        idle();
        repeat (5) step();

        // x0 discard
        p0_valid = 1; p0_addr = 0; p0_data = 32'h55;
        step(); idle();
        for (int k = 0; k < 3; k++) begin
            chk("x0 regwe", regwe, 0);
            step();
        end

        // scoreboard: two reservations, two retires
        reserve_valid = 1; reserve_addr = 7;
        step(); step();
        reserve_valid = 0; query_addr0 = 7;
        #1 chk("sb busy after 2 rsv", busy0, 1);
        p0_valid = 1; p0_addr = 7; p0_data = 32'hA1;
        step(); idle(); step(); step();
        chk("sb busy after 1 retire", busy0, 1);
        p0_valid = 1; p0_addr = 7; p0_data = 32'hA2;
        step(); idle(); step(); step();
        chk("sb busy after 2 retires", busy0, 0);

        // reserve and retire on the same edge
        reserve_valid = 1; reserve_addr = 7;
        step(); reserve_valid = 0;
        p0_valid = 1; p0_addr = 7; p0_data = 32'hA3;
        step(); idle();
        for (int k = 0; k < 4 && !(regwe && writeaddr == 7); k++) step();
        chk("sb retire seen", regwe && writeaddr == 7, 1);
        reserve_valid = 1; reserve_addr = 7;
        step(); reserve_valid = 0;
        #1 chk("sb net zero busy", busy0, 1);

        // saturate counter at CMAX
        reserve_valid = 1; reserve_addr = 7;
        repeat (CMAX - 1) step();
        #1 chk("sat reserve_ready", reserve_ready, 0);
        step();
        reserve_valid = 0;

        // reset with buffered entries
        p0_valid = 1; p0_addr = 12; p0_data = 32'hC0;
        p1_valid = 1; p1_addr = 13; p1_data = 32'hC1;
        repeat (3) step();
        idle(); reset = 1;
        step();
        reset = 0;
        chk("midrst regwe", regwe, 0);
        chk("midrst writeaddr", writeaddr, 0);
        chk("midrst writedata", writedata, 0);
        #1 chk("midrst busy0", busy0, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("midrst no regwe", regwe, 0);
        end

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset         = ($urandom_range(0, 99) == 0);
            p0_valid      = $urandom_range(0, 1);
            p0_addr       = 5'($urandom_range(0, 7));
            p0_data       = $urandom;
            p1_valid      = $urandom_range(0, 1);
            p1_addr       = 5'($urandom_range(0, 7));
            p1_data       = $urandom;
            reserve_valid = ($urandom_range(0, 2) == 0);
            reserve_addr  = 5'($urandom_range(0, 7));
            query_addr0   = 5'($urandom_range(0, 7));
            query_addr1   = 5'($urandom_range(0, 7));
            step();
        end
        reset = 0; idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
